// File: rtl/rob_commit_ctrl.sv
// In-order rename-tag allocator and commit sequencer. Tags are handed out at
// issue, results are collected per tag, and at most one entry retires per cycle.
module rob_commit_ctrl #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  output logic [4:0]  issue_tag,
  input  logic        wb_valid,
  input  logic [4:0]  wb_tag,
  input  logic [31:0] wb_val,
  output logic        commit,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_val,
  output logic [4:0]  commit_rename,
  output logic        empty,
  output logic        full
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [TAG_W-1:0] NO_RENAME = '1;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [4:0]       rd_q  [DEPTH];
  logic [4:0]       rd_d  [DEPTH];
  logic [31:0]      val_q [DEPTH];
  logic [31:0]      val_d [DEPTH];
  logic [IW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             commit_q, commit_d;
  logic [4:0]       commit_rd_q, commit_rd_d;
  logic [31:0]      commit_val_q, commit_val_d;
  logic [4:0]       commit_rename_q, commit_rename_d;
  logic             empty_q, empty_d, full_q, full_d;

  logic [IW-1:0] wb_idx;
  logic          wb_in_range;
  logic          commit_fire, issue_accept, wb_accept;

  assign wb_idx      = wb_tag[IW-1:0];
  assign wb_in_range = (wb_tag < TAG_W'(DEPTH));

  // Commit decisions use registered done bits, so a result written back this
  // edge can retire no earlier than the following edge.
  assign commit_fire  = !clear && busy_q[head_q] && done_q[head_q];
  assign issue_accept = !clear && issue_valid && !full_q;
  assign wb_accept    = !clear && wb_valid && wb_in_range && busy_q[wb_idx]
                        && !(commit_fire && (wb_idx == head_q));

  always_comb begin
    busy_d          = busy_q;
    done_d          = done_q;
    rd_d            = rd_q;
    val_d           = val_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    commit_d        = 1'b0;
    commit_rd_d     = commit_rd_q;
    commit_val_d    = commit_val_q;
    commit_rename_d = commit_rename_q;
    if (clear) begin
      busy_d  = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wb_accept) begin
        done_d[wb_idx] = 1'b1;
        val_d[wb_idx]  = wb_val;
      end
      if (commit_fire) begin
        commit_d        = 1'b1;
        commit_rd_d     = rd_q[head_q];
        commit_val_d    = val_q[head_q];
        commit_rename_d = TAG_W'(head_q);
        busy_d[head_q]  = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = (head_q == IW'(DEPTH - 1)) ? '0 : head_q + 1'b1;
      end
      if (issue_accept) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        rd_d[tail_q]   = issue_rd;
        tail_d         = (tail_q == IW'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
      end
      count_d = count_q + CW'(issue_accept) - CW'(commit_fire);
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q          <= '0;
      done_q          <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      commit_q        <= 1'b0;
      commit_rd_q     <= '0;
      commit_val_q    <= '0;
      commit_rename_q <= NO_RENAME;
      empty_q         <= 1'b1;
      full_q          <= 1'b0;
    end else if (rdy_in) begin
      busy_q          <= busy_d;
      done_q          <= done_d;
      rd_q            <= rd_d;
      val_q           <= val_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      commit_q        <= commit_d;
      commit_rd_q     <= commit_rd_d;
      commit_val_q    <= commit_val_d;
      commit_rename_q <= commit_rename_d;
      empty_q         <= empty_d;
      full_q          <= full_d;
    end
  end

  assign issue_ready   = !full_q;
  assign issue_tag     = TAG_W'(tail_q);
  assign commit        = commit_q;
  assign commit_rd     = commit_rd_q;
  assign commit_val    = commit_val_q;
  assign commit_rename = commit_rename_q;
  assign empty         = empty_q;
  assign full          = full_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: directed scenarios plus random traffic, all
// checked against an in-order queue model of the in-flight instructions.
module tb_rob_commit_ctrl;
  localparam int DEPTH = 16;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, issue_valid, wb_valid;
  logic [4:0]  issue_rd, wb_tag;
  logic [31:0] wb_val;
  logic        issue_ready, commit, empty, full;
  logic [4:0]  issue_tag, commit_rd, commit_rename;
  logic [31:0] commit_val;

  rob_commit_ctrl #(.DEPTH(DEPTH), .TAG_W(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .issue_tag(issue_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
    .commit(commit), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rename(commit_rename), .empty(empty), .full(full)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: in-flight instructions in program order.
  typedef struct {
    logic [4:0]  tag;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] val;
  } ent_t;
  ent_t        mq[$];
  int          m_tail;
  logic        m_commit;
  logic [4:0]  m_rd, m_rename;
  logic [31:0] m_val;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, rdy, clr, iv, input logic [4:0] ird,
                            input logic wv, input logic [4:0] wt, input logic [31:0] wval);
    bit fire, accept;
    ent_t e;
    if (rst) begin
      mq.delete(); m_tail = 0;
      m_commit = 0; m_rd = 0; m_val = 0; m_rename = 5'h1F;
    end else if (!rdy) begin
      // everything holds
    end else if (clr) begin
      mq.delete(); m_tail = 0; m_commit = 0;
    end else begin
      fire   = (mq.size() > 0) && mq[0].done;
      accept = iv && (mq.size() < DEPTH);
      if (wv) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].tag == wt && !(fire && i == 0)) begin
            e = mq[i]; e.done = 1; e.val = wval; mq[i] = e;
          end
        end
      end
      m_commit = fire;
      if (fire) begin
        e = mq.pop_front();
        m_rd = e.rd; m_val = e.val; m_rename = e.tag;
      end
      if (accept) begin
        e.tag = 5'(m_tail); e.rd = ird; e.done = 0; e.val = 0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, then
  // check registered outputs just after the rising edge.
  task automatic cyc(input logic rst, rdy, clr, iv, input logic [4:0] ird,
                     input logic wv, input logic [4:0] wt, input logic [31:0] wval);
    @(negedge clk_in);
    rst_in = rst; rdy_in = rdy; clear = clr; issue_valid = iv; issue_rd = ird;
    wb_valid = wv; wb_tag = wt; wb_val = wval;
    #1;
    if (!rst) begin
      check("issue_ready", 32'(issue_ready), 32'(mq.size() < DEPTH));
      check("issue_tag", 32'(issue_tag), 32'(m_tail));
    end
    @(posedge clk_in);
    model_edge(rst, rdy, clr, iv, ird, wv, wt, wval);
    #1;
    check("commit", 32'(commit), 32'(m_commit));
    check("commit_rd", 32'(commit_rd), 32'(m_rd));
    check("commit_val", commit_val, m_val);
    check("commit_rename", 32'(commit_rename), 32'(m_rename));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
  endtask

  task automatic idle();
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset();
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_in = 1; rdy_in = 1; clear = 0; issue_valid = 0; issue_rd = 0;
    wb_valid = 0; wb_tag = 0; wb_val = 0;

    // Reset then idle
    reset(); reset(); idle();
    check("rst_commit", 32'(commit), 32'h0);
    check("rst_rename", 32'(commit_rename), 32'h1F);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_issue_tag", 32'(issue_tag), 32'h0);
    check("rst_issue_ready", 32'(issue_ready), 32'h1);

    // Single issue, writeback, retire
    cyc(0, 1, 0, 1, 5'd3, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 5'd0, 32'hDEAD_BEEF);
    check("single_no_bypass", 32'(commit), 32'h0);
    idle();
    check("single_commit", 32'(commit), 32'h1);
    check("single_rd", 32'(commit_rd), 32'd3);
    check("single_val", commit_val, 32'hDEAD_BEEF);
    check("single_rename", 32'(commit_rename), 32'h0);
    idle();
    check("single_pulse_end", 32'(commit), 32'h0);
    check("single_empty", 32'(empty), 32'h1);

    // Out-of-order writeback, in-order retire
    reset();
    cyc(0, 1, 0, 1, 5'd5, 0, 0, 0);
    cyc(0, 1, 0, 1, 5'd6, 0, 0, 0);
    cyc(0, 1, 0, 1, 5'd7, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 5'd2, 32'h22);
    cyc(0, 1, 0, 0, 0, 1, 5'd1, 32'h11);
    check("ooo_wait_head", 32'(commit), 32'h0);
    cyc(0, 1, 0, 0, 0, 1, 5'd0, 32'h00);
    idle();
    check("ooo_c0", 32'(commit_rename), 32'd0);
    idle();
    check("ooo_c1_val", commit_val, 32'h11);
    idle();
    check("ooo_c2_rd", 32'(commit_rd), 32'd7);
    idle();

    // Fill, then commit while full with issue held high
    reset();
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 1, 5'($urandom_range(0, 31)), 0, 0, 0);
    check("fill_full", 32'(full), 32'h1);
    check("fill_ready", 32'(issue_ready), 32'h0);
    cyc(0, 1, 0, 1, 5'd9, 1, 5'd0, 32'h1234);
    cyc(0, 1, 0, 1, 5'd9, 0, 0, 0);
    check("full_commit", 32'(commit), 32'h1);
    check("full_still", 32'(full), 32'h0);
    check("wrap_tag", 32'(issue_tag), 32'h0);
    cyc(0, 1, 0, 1, 5'd10, 0, 0, 0);
    check("wrap_full_again", 32'(full), 32'h1);

    // Clear against a pending head commit
    reset();
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 5'(i + 1), 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 5'd1, 32'hAA);
    cyc(0, 1, 0, 0, 0, 1, 5'd0, 32'hBB);
    cyc(0, 1, 1, 1, 5'd4, 1, 5'd2, 32'hCC);
    check("clear_no_commit", 32'(commit), 32'h0);
    check("clear_empty", 32'(empty), 32'h1);
    check("clear_tag0", 32'(issue_tag), 32'h0);
    cyc(0, 1, 0, 1, 5'd8, 0, 0, 0);

    // Stall with a commit pulse in flight
    reset();
    cyc(0, 1, 0, 1, 5'd9, 0, 0, 0);
    cyc(0, 1, 0, 1, 5'd10, 1, 5'd0, 32'h5A5A);
    idle();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 5'd11, 1, 5'd1, 32'h77);
      check("stall_commit", 32'(commit), 32'h1);
      check("stall_val", commit_val, 32'h5A5A);
      check("stall_tail", 32'(issue_tag), 32'h2);
    end
    cyc(0, 1, 0, 0, 0, 1, 5'd1, 32'h99);
    check("resume_drop", 32'(commit), 32'h0);
    idle();
    check("resume_commit", commit_val, 32'h99);

    // Random traffic
    reset();
    for (int n = 0; n < 3000; n++) begin
      logic r, y, c, iv, wv;
      logic [4:0] wt;
      r  = ($urandom_range(0, 199) == 0);
      y  = ($urandom_range(0, 9) != 0);
      c  = ($urandom_range(0, 39) == 0);
      iv = ($urandom_range(0, 9) < 6);
      wv = ($urandom_range(0, 9) < 6);
      if (mq.size() > 0 && $urandom_range(0, 7) != 0)
        wt = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        wt = 5'($urandom_range(0, 31));
      cyc(r, y, c, iv, 5'($urandom_range(0, 31)), wv, wt, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
